// File: rtl/led_pattern_pkg.sv
// Shared definitions for the LED pattern generator: mode encoding, pattern seeds
// and the default maximal-length Galois LFSR feedback masks for 4..16 LEDs.
package led_pattern_pkg;

  typedef enum logic [2:0] {
    MODE_OFF    = 3'd0,
    MODE_STATIC = 3'd1,
    MODE_COUNT  = 3'd2,
    MODE_LFSR   = 3'd3,
    MODE_SCAN   = 3'd4,
    MODE_BLINK  = 3'd5
  } mode_e;

  localparam int MAX_LED = 16;

  // Left-shift Galois masks: the polynomial without its top term.
  function automatic logic [MAX_LED-1:0] lfsr_default_mask(input int n_led);
    case (n_led)
      4:       return 16'h0009;
      5:       return 16'h0009;
      6:       return 16'h0021;
      7:       return 16'h0041;
      8:       return 16'h0071;
      9:       return 16'h0021;
      10:      return 16'h0081;
      11:      return 16'h0201;
      12:      return 16'h0C11;
      13:      return 16'h1901;
      14:      return 16'h3005;
      15:      return 16'h4001;
      16:      return 16'hA011;
      default: return 16'h0000;
    endcase
  endfunction

  // Reserved modes seed like OFF.
  function automatic logic [MAX_LED-1:0] seed(input logic [2:0]         mode,
                                              input logic [MAX_LED-1:0] static_val,
                                              input int                 n_led);
    logic [MAX_LED-1:0] ones;
    ones = 16'((32'd1 << n_led) - 32'd1);
    case (mode)
      MODE_STATIC:           return static_val;
      MODE_LFSR, MODE_BLINK: return ones;
      MODE_SCAN:             return 16'h0001;
      default:               return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// Configuration and LED drive bundle between the config register block and the
// pattern generator.
interface led_pattern_gen_if #(
  parameter int N_LED = 8,
  parameter int DIV_W = 24,
  parameter int PWM_W = 4
);
  logic             cfg_we;
  logic [2:0]       cfg_mode;
  logic [DIV_W-1:0] cfg_div;
  logic [N_LED-1:0] cfg_static;
  logic [PWM_W-1:0] cfg_duty;
  logic [N_LED-1:0] led_output;
  logic [N_LED-1:0] pattern_o;
  logic             tick_o;
  logic [2:0]       mode_o;

  modport master (
    output cfg_we, cfg_mode, cfg_div, cfg_static, cfg_duty,
    input  led_output, pattern_o, tick_o, mode_o
  );

  modport slave (
    input  cfg_we, cfg_mode, cfg_div, cfg_static, cfg_duty,
    output led_output, pattern_o, tick_o, mode_o
  );
endinterface

// File: rtl/led_prescaler.sv
// Pattern-step prescaler: counts 0..div, raises step on the terminal count and
// delivers a registered one-cycle tick alongside the stepped pattern.
module led_prescaler #(
  parameter int DIV_W = 24
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             step,
  output logic             tick_o
);
  logic [DIV_W-1:0] presc;

  assign step = (presc == div) && !clear;

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge aclk) begin
    if (areset) begin
      presc  <= '0;
      tick_o <= 1'b0;
    end else begin
      tick_o <= step;
      if (clear || step) presc <= '0;
      else               presc <= presc + DIV_W'(1);
    end
  end
endmodule

// File: rtl/led_pattern_gen.sv
// Front-panel LED pattern generator: runtime-selectable pattern, programmable
// step rate, static value and global PWM dimming.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int               N_LED      = 8,
  parameter logic [N_LED-1:0] LFSR_MASK  = N_LED'(lfsr_default_mask(N_LED)),
  parameter int               DIV_W      = 24,
  parameter int               PWM_W      = 4,
  parameter logic [2:0]       RESET_MODE = 3'd3,
  parameter logic [DIV_W-1:0] RESET_DIV  = DIV_W'(65535)
) (
  input logic             aclk,
  input logic             areset,
  led_pattern_gen_if.slave bus
);
  logic [2:0]       mode_q;
  logic [DIV_W-1:0] div_q;
  logic [PWM_W-1:0] duty_q;
  logic [PWM_W-1:0] pwm_q;
  logic [N_LED-1:0] static_q;
  logic [N_LED-1:0] pattern_q;
  logic [N_LED-1:0] pattern_nxt;
  logic [N_LED-1:0] led_q;
  logic             scan_up_q;
  logic             scan_up_nxt;
  logic             step;
  logic             tick;
  logic             pwm_on;
  logic [N_LED-1:0] cfg_seed;

  led_prescaler #(.DIV_W(DIV_W)) u_presc (
    .aclk   (aclk),
    .areset (areset),
    .clear  (bus.cfg_we),
    .div    (div_q),
    .step   (step),
    .tick_o (tick)
  );

  assign cfg_seed = N_LED'(seed(bus.cfg_mode, MAX_LED'(bus.cfg_static), N_LED));
  assign pwm_on   = (pwm_q < duty_q) || (&duty_q);

  // NOTE: defaults first so every path assigns both outputs and no latch appears.
  always_comb begin
    pattern_nxt = pattern_q;
    scan_up_nxt = scan_up_q;
    case (mode_q)
      MODE_STATIC: pattern_nxt = static_q;
      MODE_COUNT:  pattern_nxt = pattern_q + N_LED'(1);
      MODE_LFSR: begin
        // An all-zero register would lock the LFSR; recover with the seed.
        if (pattern_q == '0) pattern_nxt = '1;
        else pattern_nxt = (pattern_q << 1) ^ (pattern_q[N_LED-1] ? LFSR_MASK : '0);
      end
      MODE_SCAN: begin
        if (scan_up_q) begin
          if (pattern_q[N_LED-1]) begin
            pattern_nxt = pattern_q >> 1;
            scan_up_nxt = 1'b0;
          end else begin
            pattern_nxt = pattern_q << 1;
          end
        end else begin
          if (pattern_q[0]) begin
            pattern_nxt = pattern_q << 1;
            scan_up_nxt = 1'b1;
          end else begin
            pattern_nxt = pattern_q >> 1;
          end
        end
      end
      MODE_BLINK:  pattern_nxt = ~pattern_q;
      default:     pattern_nxt = '0;
    endcase
  end

  // NOTE: reset is synchronous and covers every register so no output is X after it.
  always_ff @(posedge aclk) begin
    if (areset) begin
      mode_q    <= RESET_MODE;
      div_q     <= RESET_DIV;
      duty_q    <= '1;
      static_q  <= '0;
      pattern_q <= N_LED'(seed(RESET_MODE, '0, N_LED));
      scan_up_q <= 1'b1;
      pwm_q     <= '0;
      led_q     <= '0;
    end else begin
      pwm_q <= pwm_q + PWM_W'(1);
      led_q <= pattern_q & {N_LED{pwm_on}};
      if (bus.cfg_we) begin
        mode_q    <= bus.cfg_mode;
        div_q     <= bus.cfg_div;
        duty_q    <= bus.cfg_duty;
        static_q  <= bus.cfg_static;
        pattern_q <= cfg_seed;
        scan_up_q <= 1'b1;
      end else if (step) begin
        pattern_q <= pattern_nxt;
        scan_up_q <= scan_up_nxt;
      end
    end
  end

  assign bus.led_output = led_q;
  assign bus.pattern_o  = pattern_q;
  assign bus.tick_o     = tick;
  assign bus.mode_o     = mode_q;
endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: stimulus queues the expected pattern of
// each step, a monitor compares whenever tick_o is presented.
module tb_led_pattern_gen;
  logic aclk = 1'b0;
  logic areset;

  led_pattern_gen_if #(.N_LED(8), .DIV_W(24), .PWM_W(4)) bus ();

  led_pattern_gen dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  always #5 aclk = ~aclk;

  int         n_checks = 0;
  int         n_fail   = 0;
  bit         mon_on   = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: every presented tick consumes one expected pattern.
  always @(negedge aclk) begin
    if (mon_on && bus.tick_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_tick @%0t: pattern_o=%0h, expected no tick", $time, bus.pattern_o);
      end else begin
        mon_exp = exp_q.pop_front();
        check("tick_pattern", bus.pattern_o, mon_exp);
      end
    end
  end

  function automatic logic [7:0] lfsr_next(input logic [7:0] p);
    if (p == 8'h00) return 8'hFF;
    return {p[6:0], 1'b0} ^ (p[7] ? 8'h71 : 8'h00);
  endfunction

  task automatic apply_cfg(input logic [2:0] mode, input logic [23:0] div,
                           input logic [7:0] stat, input logic [3:0] duty);
    bus.cfg_mode   = mode;
    bus.cfg_div    = div;
    bus.cfg_static = stat;
    bus.cfg_duty   = duty;
    bus.cfg_we     = 1'b1;
    @(posedge aclk); #1;
    bus.cfg_we     = 1'b0;
  endtask

  task automatic drain(input int budget, output int cycles);
    cycles = 0;
    while (exp_q.size() != 0 && cycles < budget) begin
      @(posedge aclk); #1;
      cycles++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout @%0t: %0d patterns still pending, expected 0", $time, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic pwm_window(input logic [7:0] lit, output int on_cnt, output int bad_cnt);
    on_cnt  = 0;
    bad_cnt = 0;
    repeat (16) begin
      if (bus.led_output === lit) on_cnt++;
      else if (bus.led_output !== 8'h00) bad_cnt++;
      @(posedge aclk); #1;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  logic [7:0] scan_tab [14] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

  initial begin
    int         cyc;
    int         ticks;
    int         on_cnt;
    int         bad_cnt;
    logic [7:0] p;

    areset         = 1'b1;
    bus.cfg_we     = 1'b0;
    bus.cfg_mode   = 3'd0;
    bus.cfg_div    = 24'd0;
    bus.cfg_static = 8'h00;
    bus.cfg_duty   = 4'h0;
    repeat (2) @(posedge aclk);
    #1;
    check("reset_mode", bus.mode_o, 3'd3);
    check("reset_pattern", bus.pattern_o, 8'hFF);
    check("reset_led", bus.led_output, 8'h00);
    check("reset_tick", bus.tick_o, 1'b0);
    areset = 1'b0;
    @(posedge aclk); #1;
    check("post_reset_led", bus.led_output, 8'hFF);
    ticks = 0;
    repeat (50) begin
      @(posedge aclk); #1;
      if (bus.tick_o) ticks++;
    end
    check("default_div_no_tick", ticks, 0);

    // LFSR full period at one step per cycle.
    exp_q.push_back(8'h8F);
    exp_q.push_back(8'h6F);
    exp_q.push_back(8'hDE);
    exp_q.push_back(8'hCD);
    p = 8'hCD;
    repeat (251) begin
      p = lfsr_next(p);
      exp_q.push_back(p);
    end
    apply_cfg(3'd3, 24'd0, 8'h00, 4'hF);
    check("lfsr_seed", bus.pattern_o, 8'hFF);
    mon_on = 1'b1;
    drain(2000, cyc);
    mon_on = 1'b0;
    check("lfsr_period_cycles", cyc, 256);

    // Static zero, then LFSR lock-up recovery from a forced zero state.
    apply_cfg(3'd1, 24'd0, 8'h00, 4'hF);
    @(posedge aclk); #1;
    check("static_zero", bus.pattern_o, 8'h00);
    apply_cfg(3'd3, 24'd9, 8'h00, 4'hF);
    repeat (2) @(posedge aclk);
    #1;
    force dut.pattern_q = 8'h00;
    #3;
    release dut.pattern_q;
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h8F);
    mon_on = 1'b1;
    drain(100, cyc);
    mon_on = 1'b0;

    // SCAN bounce, two full periods, a tick every cycle.
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 14; i++) exp_q.push_back(scan_tab[i]);
    apply_cfg(3'd4, 24'd0, 8'h00, 4'hF);
    check("scan_seed", bus.pattern_o, 8'h01);
    mon_on = 1'b1;
    drain(100, cyc);
    mon_on = 1'b0;
    check("scan_cycles", cyc, 29);

    // COUNT at div=3: full wrap, then cfg_we landing on a tick cycle.
    for (int i = 1; i < 256; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'h00);
    apply_cfg(3'd2, 24'd3, 8'h00, 4'hF);
    mon_on = 1'b1;
    drain(3000, cyc);
    mon_on = 1'b0;
    check("count_cycles", cyc, 1025);
    repeat (2) @(posedge aclk);
    #1;
    apply_cfg(3'd2, 24'd3, 8'h00, 4'hF);
    check("cfg_on_tick_no_tick", bus.tick_o, 1'b0);
    check("cfg_on_tick_no_step", bus.pattern_o, 8'h00);
    exp_q.push_back(8'h01);
    mon_on = 1'b1;
    drain(20, cyc);
    mon_on = 1'b0;
    check("count_after_cfg_cycles", cyc, 5);

    // PWM dimming of a static pattern.
    apply_cfg(3'd1, 24'd0, 8'hA5, 4'd4);
    check("static_pattern", bus.pattern_o, 8'hA5);
    @(posedge aclk); #1;
    pwm_window(8'hA5, on_cnt, bad_cnt);
    check("duty4_on_cycles", on_cnt, 4);
    check("duty4_bad_values", bad_cnt, 0);
    apply_cfg(3'd1, 24'd0, 8'hA5, 4'd0);
    @(posedge aclk); #1;
    pwm_window(8'hA5, on_cnt, bad_cnt);
    check("duty0_on_cycles", on_cnt, 0);
    check("duty0_bad_values", bad_cnt, 0);
    apply_cfg(3'd1, 24'd0, 8'hA5, 4'hF);
    @(posedge aclk); #1;
    pwm_window(8'hA5, on_cnt, bad_cnt);
    check("dutyF_on_cycles", on_cnt, 16);

    // Reset in the middle of SCAN with a simultaneous cfg_we.
    apply_cfg(3'd4, 24'd0, 8'h00, 4'hF);
    repeat (5) @(posedge aclk);
    #1;
    areset         = 1'b1;
    bus.cfg_mode   = 3'd5;
    bus.cfg_div    = 24'd0;
    bus.cfg_duty   = 4'h0;
    bus.cfg_we     = 1'b1;
    @(posedge aclk); #1;
    areset     = 1'b0;
    bus.cfg_we = 1'b0;
    check("midreset_mode", bus.mode_o, 3'd3);
    check("midreset_pattern", bus.pattern_o, 8'hFF);
    check("midreset_led", bus.led_output, 8'h00);
    check("midreset_tick", bus.tick_o, 1'b0);
    @(posedge aclk); #1;
    check("midreset_led_next", bus.led_output, 8'hFF);
    check("midreset_pattern_hold", bus.pattern_o, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
